// File: rtl/bit_pkg.sv
// Shared types for bit_extend_unpack: FSM state encoding and rail-value helper.
package bit_pkg;

  typedef enum logic {
    IDLE,
    EMIT
  } state_e;

  typedef struct packed {
    logic signed [31:0] hi;
    logic signed [31:0] lo;
  } rail_t;

  // Most-positive and most-negative values of a signed field of the given width.
  function automatic rail_t rail_values(input int unsigned width);
    rail_t r;
    r.hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    r.lo = -(32'sd1 <<< (width - 1));
    return r;
  endfunction

endpackage

// File: rtl/bit_extend_unpack_if.sv
// Packed-word input and widened-sample output handshakes of bit_extend_unpack.
interface bit_extend_unpack_if #(
  parameter int unsigned N_In   = 6,
  parameter int unsigned N_Out  = 9,
  parameter int unsigned N_Samp = 4
);
  logic [N_Samp*N_In-1:0]         IN_WORD;
  logic                           IN_VALID;
  logic                           IN_READY;
  logic signed [N_Out-1:0]        OUT;
  logic                           OUT_VALID;
  logic                           OUT_READY;
  logic                           OUT_LAST;
  logic [$clog2(N_Samp+1)-1:0]    RAIL_CNT;

  modport master (
    output IN_WORD, IN_VALID, OUT_READY,
    input  IN_READY, OUT, OUT_VALID, OUT_LAST, RAIL_CNT
  );

  modport slave (
    input  IN_WORD, IN_VALID, OUT_READY,
    output IN_READY, OUT, OUT_VALID, OUT_LAST, RAIL_CNT
  );
endinterface

// File: rtl/bit_extend.sv
// Combinational widening of one signed sample; BIT_EXTEND_SCALE_EN left-aligns it.
module bit_extend #(
  parameter int unsigned N_In  = 6,
  parameter int unsigned N_Out = 9
) (
  input  logic signed [N_In-1:0]  in_s,
  output logic signed [N_Out-1:0] out_s
);
`ifdef BIT_EXTEND_SCALE_EN
  assign out_s = N_Out'(in_s) <<< (N_Out - N_In);
`else
  assign out_s = N_Out'(in_s);
`endif
endmodule

// File: rtl/bit_extend_unpack.sv
// Unpacks N_Samp signed samples per word, widens each to N_Out bits and counts rail samples.
// Optional macro BIT_EXTEND_SCALE_EN selects left-aligned (scaled) output.
module bit_extend_unpack
  import bit_pkg::*;
#(
  parameter int unsigned N_In   = 6,
  parameter int unsigned N_Out  = 9,
  parameter int unsigned N_Samp = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  bit_extend_unpack_if.slave   bus
);

  localparam int unsigned CW   = $clog2(N_Samp);
  localparam int unsigned RW   = $clog2(N_Samp + 1);
  localparam rail_t       RAIL = rail_values(N_In);

  state_e                    state_q, state_d;
  logic [N_Samp*N_In-1:0]    word_q, word_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [RW-1:0]             rail_q, rail_d;
  logic signed [N_Out-1:0]   out_q, out_d;
  logic                      valid_q, valid_d;
  logic                      last_q, last_d;

  logic                      in_ready, in_xfer, out_xfer;
  logic [N_Samp*N_In-1:0]    sel_word;
  logic [CW-1:0]             sel_idx, cnt_inc;
  logic signed [N_In-1:0]    samp;
  logic signed [31:0]        samp32;
  logic signed [N_Out-1:0]   samp_ext;
  logic                      samp_rail;

  assign in_ready = !RST && ((state_q == IDLE) || (valid_q && last_q && bus.OUT_READY));
  assign in_xfer  = in_ready && bus.IN_VALID;
  assign out_xfer = !RST && valid_q && bus.OUT_READY;
  assign cnt_inc  = cnt_q + CW'(1);

  // One widener serves both the first sample of a new word and each following sample.
  always_comb begin
    sel_word = in_xfer ? bus.IN_WORD : word_q;
    sel_idx  = in_xfer ? '0 : cnt_inc;
    samp     = '0;
    for (int unsigned k = 0; k < N_Samp; k++) begin
      if (CW'(k) == sel_idx) samp = sel_word[k*N_In +: N_In];
    end
    samp32    = 32'(samp);
    samp_rail = (samp32 == RAIL.hi) || (samp32 == RAIL.lo);
  end

  bit_extend #(.N_In(N_In), .N_Out(N_Out)) u_ext (
    .in_s  (samp),
    .out_s (samp_ext)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    rail_d  = rail_q;
    out_d   = out_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (in_xfer) begin
      state_d = EMIT;
      word_d  = bus.IN_WORD;
      cnt_d   = '0;
      rail_d  = RW'(samp_rail);
      out_d   = samp_ext;
      valid_d = 1'b1;
      last_d  = 1'b0;
    end else if (out_xfer) begin
      if (last_q) begin
        state_d = IDLE;
        cnt_d   = '0;
        rail_d  = '0;
        out_d   = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        cnt_d   = cnt_inc;
        rail_d  = rail_q + RW'(samp_rail);
        out_d   = samp_ext;
        last_d  = (cnt_inc == CW'(N_Samp - 1));
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
      rail_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      rail_q  <= rail_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  // Outputs are forced idle while RST is high so a pending sample cannot be taken.
  assign bus.IN_READY  = in_ready;
  assign bus.OUT       = RST ? '0 : out_q;
  assign bus.OUT_VALID = !RST && valid_q;
  assign bus.OUT_LAST  = !RST && last_q;
  assign bus.RAIL_CNT  = RST ? '0 : rail_q;

endmodule

// File: tb/tb_bit_extend_unpack.sv
// Directed bench for bit_extend_unpack (N_In=6, N_Out=9, N_Samp=4); honours BIT_EXTEND_SCALE_EN.
module tb_bit_extend_unpack;

  localparam int unsigned N_In   = 6;
  localparam int unsigned N_Out  = 9;
  localparam int unsigned N_Samp = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bit_extend_unpack_if #(.N_In(N_In), .N_Out(N_Out), .N_Samp(N_Samp)) bus ();

  bit_extend_unpack #(.N_In(N_In), .N_Out(N_Out), .N_Samp(N_Samp)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [8:0]  e [4];
  logic [23:0] w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef BIT_EXTEND_SCALE_EN
    e = '{9'h028, 9'h1F8, 9'h0F8, 9'h100};
`else
    e = '{9'h005, 9'h1FF, 9'h01F, 9'h1E0};
`endif
    w             = 24'h81FFC5;
    rst           = 1'b1;
    bus.IN_VALID  = 1'b0;
    bus.IN_WORD   = '0;
    bus.OUT_READY = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out",   {bus.OUT},       0);
    chk("rst_valid", {bus.OUT_VALID}, 0);
    chk("rst_last",  {bus.OUT_LAST},  0);
    chk("rst_rail",  {bus.RAIL_CNT},  0);
    chk("rst_ready", {bus.IN_READY},  0);

    @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_first_cycle", {bus.IN_READY}, 1);

    // Basic word; IN_WORD is scrambled after acceptance
    bus.IN_WORD  = w;
    bus.IN_VALID = 1'b1;
    @(negedge clk);
    bus.IN_VALID = 1'b0;
    bus.IN_WORD  = 24'hFFFFFF;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      chk("a_out",   {bus.OUT},       {23'b0, e[k]});
      chk("a_valid", {bus.OUT_VALID}, 1);
      chk("a_last",  {bus.OUT_LAST},  32'(k == 3));
      chk("a_ready", {bus.IN_READY},  32'(k == 3));
      if (k == 3) chk("a_rail", {bus.RAIL_CNT}, 2);
    end
    @(negedge clk);
    #1;
    chk("a_idle_valid", {bus.OUT_VALID}, 0);
    chk("a_idle_ready", {bus.IN_READY},  1);

    // Stall at sample 1 for three cycles
    bus.IN_WORD  = w;
    bus.IN_VALID = 1'b1;
    @(negedge clk);
    bus.IN_VALID = 1'b0;
    #1 chk("b_out0", {bus.OUT}, {23'b0, e[0]});
    @(negedge clk);
    bus.OUT_READY = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("b_stall_out",   {bus.OUT},       {23'b0, e[1]});
      chk("b_stall_valid", {bus.OUT_VALID}, 1);
      chk("b_stall_ready", {bus.IN_READY},  0);
      chk("b_stall_last",  {bus.OUT_LAST},  0);
      @(negedge clk);
      #1;
    end
    bus.OUT_READY = 1'b1;
    chk("b_resume_out1", {bus.OUT}, {23'b0, e[1]});
    @(negedge clk);
    #1 chk("b_out2", {bus.OUT}, {23'b0, e[2]});
    @(negedge clk);
    #1;
    chk("b_out3",  {bus.OUT},      {23'b0, e[3]});
    chk("b_last",  {bus.OUT_LAST}, 1);
    chk("b_rail",  {bus.RAIL_CNT}, 2);
    @(negedge clk);
    #1 chk("b_idle_valid", {bus.OUT_VALID}, 0);

    // Back-to-back words; second word is all zeros
    bus.IN_WORD  = w;
    bus.IN_VALID = 1'b1;
    @(negedge clk);
    bus.IN_WORD = 24'h000000;
    #1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        @(negedge clk);
        if (i == 4) bus.IN_VALID = 1'b0;
        #1;
      end
      chk("c_valid", {bus.OUT_VALID}, 1);
      chk("c_out",   {bus.OUT},       (i < 4) ? {23'b0, e[i]} : 32'd0);
      chk("c_last",  {bus.OUT_LAST},  32'(i == 3 || i == 7));
      if (i < 4) chk("c_ready", {bus.IN_READY}, 32'(i == 3));
      if (i == 3) chk("c_rail_w1", {bus.RAIL_CNT}, 2);
      if (i == 7) chk("c_rail_w2", {bus.RAIL_CNT}, 0);
    end
    @(negedge clk);
    #1 chk("c_idle_valid", {bus.OUT_VALID}, 0);

    // Reset pulse after sample 1 discards the rest of the word
    bus.IN_WORD  = w;
    bus.IN_VALID = 1'b1;
    @(negedge clk);
    bus.IN_VALID = 1'b0;
    #1 chk("d_out0", {bus.OUT}, {23'b0, e[0]});
    @(negedge clk);
    #1 chk("d_out1", {bus.OUT}, {23'b0, e[1]});
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("d_rst_valid", {bus.OUT_VALID}, 0);
    chk("d_rst_out",   {bus.OUT},       0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("d_ready_after", {bus.IN_READY},  1);
    chk("d_valid_after", {bus.OUT_VALID}, 0);
    repeat (3) begin
      @(negedge clk);
      #1 chk("d_no_tail", {bus.OUT_VALID}, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_extend_unpack.md
BIT_EXTEND_UNPACK -- requirements
Module: bit_extend_unpack

Interface
REQ-001 SHALL have parameter N_In, default 6, meaning the signed width of each packed sample.
REQ-002 SHALL have parameter N_Out, default 9, meaning the signed width of each emitted sample; N_Out >= N_In.
REQ-003 SHALL have parameter N_Samp, default 4, meaning the number of samples per packed word; N_Samp >= 2.
REQ-004 CLK  input  1  the single clock; all logic is rising-edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 IN_WORD  input  N_Samp*N_In  packed signed samples; sample k occupies bits [k*N_In +: N_In].
REQ-007 IN_VALID  input  1  IN_WORD is valid.
REQ-008 IN_READY  output  1  the block accepts IN_WORD this cycle.
REQ-009 OUT  output  N_Out (signed)  the widened sample.
REQ-010 OUT_VALID  output  1  OUT is valid.
REQ-011 OUT_READY  input  1  the downstream block accepts OUT this cycle.
REQ-012 OUT_LAST  output  1  OUT carries sample N_Samp-1 of the current word.
REQ-013 RAIL_CNT  output  $clog2(N_Samp+1)  count of rail samples in the current word; valid when OUT_VALID && OUT_LAST.

Function
REQ-014 The block SHALL complete a word transfer when IN_VALID && IN_READY, and an output transfer when OUT_VALID && OUT_READY.
REQ-015 The block SHALL use an FSM with states IDLE and EMIT; IDLE -> EMIT on word transfer; EMIT -> IDLE on transfer of the last sample with no word transfer in that cycle.
REQ-016 IN_READY SHALL be 1 in IDLE, and 1 in EMIT only when OUT_VALID && OUT_LAST && OUT_READY, giving back-to-back words with no bubble.
REQ-017 A word accepted at cycle t SHALL present sample 0 on OUT with OUT_VALID=1 at cycle t+1.
REQ-018 Samples SHALL be emitted in order k = 0 .. N_Samp-1, one per output transfer, under a sample counter that wraps to 0 after N_Samp-1.
REQ-019 While OUT_VALID && !OUT_READY, OUT, OUT_LAST and RAIL_CNT SHALL hold stable.
REQ-020 OUT SHALL be the sign extension of sample k to N_Out bits.
REQ-021 A sample is a rail sample when it equals 2^(N_In-1)-1 or -2^(N_In-1); RAIL_CNT SHALL accumulate these over samples 0..N_Samp-1 and SHALL restart at 0 for each new word.
REQ-022 IN_WORD SHALL be registered on word transfer, so later changes on IN_WORD do not affect samples already accepted.
REQ-023 OUT_VALID SHALL be 0 in IDLE.

Reset
REQ-024 While RST=1, the block SHALL drive OUT=0, OUT_VALID=0, OUT_LAST=0, RAIL_CNT=0 and IN_READY=0, set the FSM to IDLE, and clear the sample counter and the word register.
REQ-025 RST asserted during EMIT SHALL discard the partial word, and no remaining sample of that word SHALL appear after reset is released.
REQ-026 IN_READY SHALL be 1 in the first cycle with RST=0.

Configuration
REQ-027 When the macro BIT_EXTEND_SCALE_EN is defined, OUT SHALL be the sign-extended sample shifted left by N_Out-N_In with zero fill, giving a left-aligned full-scale value.
REQ-028 When BIT_EXTEND_SCALE_EN is undefined, OUT SHALL be the plain sign extension, and no shifter logic SHALL be present.

Structure
REQ-029 The FSM state enum (IDLE, EMIT) SHALL live in the shared package bit_pkg, together with a function that returns the rail values for a given width.
REQ-030 The per-sample widening SHALL be a sub-module named bit_extend (combinational, parameters N_In and N_Out), instantiated once.

Verification
Parameters for all scenarios: N_In=6, N_Out=9, N_Samp=4.
REQ-031 Scenario: IN_WORD=24'h81FFC5, OUT_READY=1, scale off -> OUT = 9'h005, 9'h1FF, 9'h01F, 9'h1E0; OUT_LAST only on the 4th sample; RAIL_CNT=2.
REQ-032 Scenario: the same word with BIT_EXTEND_SCALE_EN defined -> OUT = 9'h028, 9'h1F8, 9'h0F8, 9'h100.
REQ-033 Scenario: OUT_READY=0 for 3 cycles at sample 1 -> OUT holds 9'h1FF and IN_READY=0 for those cycles; the sequence then resumes unchanged.
REQ-034 Scenario: two words back-to-back with IN_VALID held high -> 8 consecutive OUT_VALID cycles with no gap; the second word is accepted in the cycle of the first word's last transfer.
REQ-035 Scenario: RST pulsed for 1 cycle after sample 1 -> OUT_VALID=0 next cycle, IN_READY=1 the cycle after, and no samples 2 or 3 appear.
REQ-036 Scenario: word 24'h000000 -> four outputs of 9'h000 and RAIL_CNT=0.
